// File: rtl/spi_rx_fifo.sv
// rtl/spi_rx_fifo.sv - SPI receive frame FIFO with sticky overrun and status flags.
// Optional trailing-CRC frame check is built when SPI_RX_CRC_CHK_EN is defined.
module spi_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk_rx,
  input  logic          spi_rx_rst,
  input  logic [1:0]    df,
  input  logic          crc_en,
  input  logic          rx_busy,
  input  logic [31:0]   spi_rx_data,
  input  logic          rx_crc_en,
  input  logic [31:0]   rx_crc_data_out,
  input  logic          rd_en,
  input  logic          ovr_clr,
  input  logic          crcerr_clr,
  output logic [31:0]   rd_data,
  output logic          rxne,
  output logic          full,
  output logic [AW:0]   level,
  output logic          ovr,
  output logic          crc_err,
  output logic          crc_done
);

  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          busy_d;
  logic          frame_done;
  logic          data_frame;
  logic          wr_ok;
  logic          pop;
  logic          ovr_set;

  assign frame_done = busy_d & ~rx_busy;
  assign rxne       = (level != '0);
  assign full       = (level == (AW+1)'(DEPTH));
  assign pop        = rd_en & rxne;

`ifdef SPI_RX_CRC_CHK_EN
  logic        crc_frame;
  logic        crc_mismatch;
  logic [31:0] crc_mask;

  assign crc_frame  = frame_done & rx_crc_en & crc_en;
  assign data_frame = frame_done & ~rx_crc_en;

  always_comb begin
    crc_mask = 32'hFFFF_FFFF;
    case (df)
      2'b00:   crc_mask = 32'h0000_00FF;
      2'b01:   crc_mask = 32'h0000_FFFF;
      default: crc_mask = 32'hFFFF_FFFF;
    endcase
  end

  assign crc_mismatch = (((spi_rx_data ^ rx_crc_data_out) & crc_mask) != 32'h0);

  always_ff @(posedge clk_rx) begin
    if (spi_rx_rst) begin
      crc_err  <= 1'b0;
      crc_done <= 1'b0;
    end else begin
      crc_done <= crc_frame;
      // A mismatch in the same cycle as a clear keeps the flag set.
      if (crc_frame && crc_mismatch) begin
        crc_err <= 1'b1;
      end else if (crcerr_clr) begin
        crc_err <= 1'b0;
      end
    end
  end
`else
  logic unused_crc_inputs;

  // Without the checker every completed frame, CRC included, is data.
  assign data_frame        = frame_done;
  assign crc_err           = 1'b0;
  assign crc_done          = 1'b0;
  assign unused_crc_inputs = ^{df, crc_en, rx_crc_en, rx_crc_data_out, crcerr_clr};
`endif

  // A full FIFO still accepts a word when a pop frees a slot at the same edge.
  assign wr_ok   = data_frame & (~full | rd_en);
  assign ovr_set = data_frame & full & ~rd_en;

  always_ff @(posedge clk_rx) begin
    if (wr_ok) begin
      mem[wr_ptr] <= spi_rx_data;
    end
  end

  always_ff @(posedge clk_rx) begin
    if (spi_rx_rst) begin
      busy_d  <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rd_data <= 32'h0;
      ovr     <= 1'b0;
    end else begin
      busy_d <= rx_busy;
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      if (wr_ok && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !wr_ok) begin
        level <= level - 1'b1;
      end
      if (ovr_set) begin
        ovr <= 1'b1;
      end else if (ovr_clr) begin
        ovr <= 1'b0;
      end
    end
  end

endmodule
